// File: rtl/muldiv_ctrl_if.sv
// EX-side mul/div request, HI/LO move and result bundle.
// The master modport is the pipeline side; the slave modport is the sequencer.
interface muldiv_ctrl_if #(
  parameter int unsigned DATA_W = 32
);

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              flush;
  logic              whi;
  logic              wlo;
  logic [DATA_W-1:0] wdata;
  logic              stall_req;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, operand_1, operand_2, flush, whi, wlo, wdata,
    input  stall_req, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_1, operand_2, flush, whi, wlo, wdata,
    output stall_req, busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. One iteration per cycle on
// operand magnitudes (shift-add multiply, restoring divide), sign fix-up at commit.
module muldiv_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] acc_hi_q;
  logic [DATA_W-1:0] acc_lo_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              is_div_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              done_q;
  logic              dbz_q;

  logic              op_div;
  logic              op_signed;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  assign op_div    = bus.op[1];
  assign op_signed = bus.op[0];
  assign a_neg     = op_signed & bus.operand_1[DATA_W-1];
  assign b_neg     = op_signed & bus.operand_2[DATA_W-1];
  assign a_mag     = a_neg ? -bus.operand_1 : bus.operand_1;
  assign b_mag     = b_neg ? -bus.operand_2 : bus.operand_2;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_sub;
  logic                div_ok;
  logic [DATA_W-1:0]   iter_hi;
  logic [DATA_W-1:0]   iter_lo;
  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  // acc_lo holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB
  // first, quotient bits shifted in); acc_hi holds the partial product or remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ok    = div_shift >= {1'b0, opb_q};
    div_sub   = div_shift[DATA_W-1:0] - opb_q;
    if (is_div_q) begin
      iter_hi = div_ok ? div_sub : div_shift[DATA_W-1:0];
      iter_lo = {acc_lo_q[DATA_W-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[DATA_W:1];
      iter_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end
    prod_raw = {iter_hi, iter_lo};
    prod     = neg_quo_q ? -prod_raw : prod_raw;
    quo      = neg_quo_q ? -iter_lo : iter_lo;
    rem      = neg_rem_q ? -iter_hi : iter_hi;
    res_hi   = is_div_q ? rem : prod[2*DATA_W-1:DATA_W];
    res_lo   = is_div_q ? quo : prod[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.flush) begin
            is_div_q  <= op_div;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= a_mag;
            opb_q     <= b_mag;
            if (op_div && bus.operand_2 == '0) begin
              state_q <= StDone;
              hi_q    <= bus.operand_1;
              lo_q    <= '1;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end else if (!bus.start) begin
            if (bus.whi) hi_q <= bus.wdata;
            if (bus.wlo) lo_q <= bus.wdata;
          end
        end
        StRun: begin
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            acc_hi_q <= iter_hi;
            acc_lo_q <= iter_lo;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StDone;
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          // start here is the same instruction still leaving EX
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.stall_req   = (state_q == StIdle && bus.start && !bus.flush) || (state_q == StRun);
  assign bus.busy        = state_q != StIdle;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the EX stage of the 5-stage pipeline; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from EX and iterates one bit per cycle (shift-add multiply, restoring divide).
- Raises a stall request to pipeline control until the result is committed; supports flush and MTHI/MTLO writes.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count = DATA_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
start  input  1  EX holds a mul/div instruction this cycle
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
operand_1  input  DATA_W  multiplicand / dividend
operand_2  input  DATA_W  multiplier / divisor
flush  input  1  kill in-flight operation
whi  input  1  MTHI write
wlo  input  1  MTLO write
wdata  input  DATA_W  MTHI/MTLO data
stall_req  output  1  hold IF/ID/EX (combinational)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, result committed
div_by_zero  output  1  valid with done
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register

Behaviour:
- Reset: state=IDLE; hi, lo, done, div_by_zero, busy, iteration counter, internal regs = 0; stall_req=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 and flush=0 -> latch |operand_1|, |operand_2| (magnitudes for MULT/DIV, raw for unsigned), latch result-sign info, counter=0, go RUN. Divide with operand_2==0 -> go DONE directly.
- RUN: one iteration per cycle; after DATA_W iterations (counter==DATA_W-1) go DONE, committing hi/lo on that edge.
- DONE: done=1, stall_req=0, go IDLE. start in DONE is ignored (same instruction leaving EX).
- stall_req = (state==IDLE & start & ~flush) | (state==RUN).
- Latency: start sampled at cycle 0 -> done and new hi/lo visible at cycle DATA_W+1 (33); stall_req high cycles 0..32.
- Multiply: 2*DATA_W product; {hi,lo}=product; MULT negates the 64-bit product when operand signs differ.
- Divide: lo=quotient, hi=remainder. DIV: quotient negated if signs differ; remainder takes dividend sign. 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
- Divide by zero: one-cycle latency (done at cycle 1), div_by_zero=1 with done, lo=all ones, hi=operand_1. div_by_zero=0 on every other done.
- Flush: any state -> IDLE next edge; hi/lo unchanged, no done pulse. flush with start in IDLE: flush wins, no launch.
- MTHI/MTLO: in IDLE with start=0, whi/wlo write wdata into hi/lo next edge (both may be set). Ignored when busy or when start=1.
- Async reset mid-operation: immediate return to reset values; no done.

Test Plan:
- MULTU 0xFFFFFFFF x 0x00000002 -> stall_req cycles 0-32, done at cycle 33, hi=0x00000001, lo=0xFFFFFFFE.
- MULT 0xFFFFFFFD(-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x0000000A / 0 -> done at cycle 1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x0000000A; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Load hi=0x1234, lo=0x5678 via MTHI/MTLO; start DIVU 100/7, flush at cycle 10 -> IDLE at cycle 11, no done, hi/lo remain 0x1234/0x5678.
- Start held high through DONE -> single operation only, busy=0 the cycle after done; MTLO asserted with start in IDLE -> write dropped.
- rst=0 at cycle 15 of a MULTU -> hi, lo, busy, stall_req = 0 immediately; after release, a new MULTU 3x4 gives lo=12 at cycle 33.
